// File: rtl/obs_pkg.sv
// Shared definitions for the odd/even overlap-free GF(2) multiplier recombination.
// Tag ids, FSM encoding and operand/product width helpers.
package obs_pkg;

  localparam logic [1:0] TAG_EE = 2'd0;
  localparam logic [1:0] TAG_EO = 2'd1;
  localparam logic [1:0] TAG_OE = 2'd2;
  localparam logic [1:0] TAG_OO = 2'd3;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  function automatic int sub_width(input int n);
    return n - 1;
  endfunction

  function automatic int prod_width(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/overlap_accum_seq_if.sv
// Sub-product input stream, product output stream and control for overlap_accum_seq.
// master = producer/consumer side, slave = the recombination block.
interface overlap_accum_seq_if #(
  parameter int N = 36
) ();

  logic                                 clear;
  logic                                 in_valid;
  logic                                 in_ready;
  logic [1:0]                           in_tag;
  logic [obs_pkg::sub_width(N)-1:0]     in_data;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [obs_pkg::prod_width(N)-1:0]    out_data;
  logic                                 dup_err;

  modport master (
    output clear, in_valid, in_tag, in_data, out_ready,
    input  in_ready, out_valid, out_data, dup_err
  );

  modport slave (
    input  clear, in_valid, in_tag, in_data, out_ready,
    output in_ready, out_valid, out_data, dup_err
  );

endinterface

// File: rtl/overlap_accum_seq_spread.sv
// Places one N-1 bit sub-product at its interleaved position in the 2N-1 bit product.
// EE lands on even bits, OO on even bits shifted by two, EO/OE on odd bits.
module overlap_spread
  import obs_pkg::*;
#(
  parameter int N = 36
) (
  input  logic [1:0]                 tag,
  input  logic [sub_width(N)-1:0]    term,
  output logic [prod_width(N)-1:0]   contrib
);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    contrib = '0;
    for (int k = 0; k < N - 1; k++) begin
      unique case (tag)
        TAG_EE:  contrib[2*k]     = term[k];
        TAG_OO:  contrib[2*k + 2] = term[k];
        default: contrib[2*k + 1] = term[k];
      endcase
    end
  end

endmodule

// File: rtl/overlap_accum_seq.sv
// Sequential recombination stage: XOR-accumulates EE/EO/OE/OO sub-products in any order
// and holds the finished 2N-1 bit product on a valid/ready output.
module overlap_accum_seq
  import obs_pkg::*;
#(
  parameter int N = 36
) (
  input  logic                clk,
  input  logic                rst_n,
  overlap_accum_seq_if.slave  bus
);

  localparam int PW = prod_width(N);

  state_e          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [3:0]      seen_q, seen_d;
  logic [PW-1:0]   out_data_q, out_data_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            dup_err_q, dup_err_d;
  logic [PW-1:0]   contrib;
  logic            accept;

  overlap_spread #(.N(N)) u_spread (
    .tag     (bus.in_tag),
    .term    (bus.in_data),
    .contrib (contrib)
  );

  assign accept = bus.in_valid & in_ready_q & ~bus.clear;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    seen_d      = seen_q;
    out_data_d  = out_data_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    dup_err_d   = 1'b0;

    if (bus.clear) begin
      // Abort wins over any beat or pending product in the same cycle.
      state_d     = COLLECT;
      acc_d       = '0;
      seen_d      = 4'b0000;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (accept) begin
            if (seen_q[bus.in_tag]) begin
              dup_err_d = 1'b1;
            end else begin
              acc_d                = acc_q ^ contrib;
              seen_d[bus.in_tag]   = 1'b1;
              if (seen_d == 4'b1111) begin
                state_d     = HOLD;
                out_data_d  = acc_d;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b1;
              end
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_d     = COLLECT;
            acc_d       = '0;
            seen_d      = 4'b0000;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      acc_q       <= '0;
      seen_q      <= 4'b0000;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dup_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      seen_q      <= seen_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dup_err_q   <= dup_err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.dup_err   = dup_err_q;

endmodule

// File: tb/tb_overlap_accum_seq.sv
// Self-checking bench for overlap_accum_seq at N=4: scoreboarded products,
// duplicate-tag pulse, backpressure, clear and asynchronous reset.
module tb_overlap_accum_seq;

  localparam int N  = 4;
  localparam int W  = N - 1;
  localparam int P  = 2 * N - 1;
  localparam int TIMEOUT = 20;

  logic clk;
  logic rst_n;

  overlap_accum_seq_if #(.N(N)) bus ();

  overlap_accum_seq #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_vec;
  int           n_err;
  logic [P-1:0] exp_q[$];

  // Closed-form recombination over all four terms.
  function automatic logic [P-1:0] model(input logic [W-1:0] ee, eo, oe, oo);
    logic [P-1:0] r;
    r = '0;
    r[0] = ee[0];
    for (int k = 1; k <= N - 2; k++) r[2*k] = ee[k] ^ oo[k-1];
    r[2*N-2] = oo[N-2];
    for (int k = 0; k <= N - 2; k++) r[2*k+1] = eo[k] ^ oe[k];
    return r;
  endfunction

  task automatic send_beat(input logic [1:0] tag, input logic [W-1:0] data);
    int waited;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_tag   = tag;
    bus.in_data  = data;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    n_vec++;
    if (waited >= TIMEOUT) begin
      $display("FAIL beat_accept: in_ready=%b after %0d cycles, required 1", bus.in_ready, waited);
      n_err++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Sends four beats in the given order; checks the product is flagged right after the last edge.
  task automatic load_product(input logic [1:0] tags[4], input logic [W-1:0] data[4],
                              input logic [P-1:0] expected, input string name);
    exp_q.push_back(expected);
    for (int i = 0; i < 4; i++) send_beat(tags[i], data[i]);
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      $display("FAIL %s_latency: out_valid=%b in_ready=%b, required 1/0", name, bus.out_valid, bus.in_ready);
      n_err++;
    end
  endtask

  task automatic collect(input string name);
    int           waited;
    logic [P-1:0] exp;
    @(negedge clk);
    waited = 0;
    while (bus.out_valid !== 1'b1 && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    n_vec++;
    if (waited >= TIMEOUT) begin
      $display("FAIL %s_timeout: out_valid=%b, required 1", name, bus.out_valid);
      n_err++;
      return;
    end
    if (exp_q.size() == 0) begin
      $display("FAIL %s_scoreboard: got %b with no expected product queued", name, bus.out_data);
      n_err++;
      return;
    end
    exp = exp_q.pop_front();
    if (bus.out_data !== exp) begin
      $display("FAIL %s_data: out_data=%b, required %b", name, bus.out_data, exp);
      n_err++;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== exp) begin
      $display("FAIL %s_release: out_valid=%b in_ready=%b out_data=%b, required 0/1/%b",
               name, bus.out_valid, bus.in_ready, bus.out_data, exp);
      n_err++;
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.dup_err !== 1'b0) begin
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%b dup_err=%b, required 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.dup_err);
      n_err++;
    end
  endtask

  task automatic test_single_term();
    logic [1:0]   tags[4];
    logic [W-1:0] d[4];
    tags = '{2'd0, 2'd1, 2'd2, 2'd3};
    d    = '{3'b001, 3'b000, 3'b000, 3'b000};
    load_product(tags, d, 7'b0000001, "single_ee");
    collect("single_ee");
    d    = '{3'b000, 3'b000, 3'b000, 3'b001};
    load_product(tags, d, 7'b0000100, "single_oo");
    collect("single_oo");
  endtask

  task automatic test_cross_terms();
    logic [1:0]   tags[4];
    logic [W-1:0] d[4];
    tags = '{2'd0, 2'd1, 2'd2, 2'd3};
    d    = '{3'b000, 3'b111, 3'b101, 3'b000};
    load_product(tags, d, 7'b0001000, "cross_fwd");
    collect("cross_fwd");
    tags = '{2'd3, 2'd2, 2'd1, 2'd0};
    d    = '{3'b000, 3'b101, 3'b111, 3'b000};
    load_product(tags, d, 7'b0001000, "cross_rev");
    collect("cross_rev");
  endtask

  task automatic test_cancel();
    logic [1:0]   tags[4];
    logic [W-1:0] d[4];
    tags = '{2'd0, 2'd3, 2'd1, 2'd2};
    d    = '{3'b111, 3'b111, 3'b000, 3'b000};
    load_product(tags, d, 7'b1000001, "cancel");
    collect("cancel");
  endtask

  task automatic test_dup();
    exp_q.push_back(7'b0000001);
    send_beat(2'd0, 3'b001);
    n_vec++;
    if (bus.dup_err !== 1'b0) begin
      $display("FAIL dup_first: dup_err=%b, required 0", bus.dup_err);
      n_err++;
    end
    send_beat(2'd0, 3'b010);
    n_vec++;
    if (bus.dup_err !== 1'b1) begin
      $display("FAIL dup_pulse: dup_err=%b, required 1", bus.dup_err);
      n_err++;
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.dup_err !== 1'b0) begin
      $display("FAIL dup_width: dup_err=%b one cycle later, required 0", bus.dup_err);
      n_err++;
    end
    send_beat(2'd1, 3'b000);
    send_beat(2'd2, 3'b000);
    send_beat(2'd3, 3'b000);
    collect("dup");
  endtask

  task automatic test_backpressure();
    logic [1:0]   tags[4];
    logic [W-1:0] d[4];
    logic [P-1:0] exp;
    tags = '{2'd1, 2'd0, 2'd3, 2'd2};
    d    = '{3'b110, 3'b011, 3'b101, 3'b010};
    exp  = model(3'b011, 3'b110, 3'b010, 3'b101);
    load_product(tags, d, exp, "bp");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== exp) begin
        $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b out_data=%b, required 1/0/%b",
                 c, bus.out_valid, bus.in_ready, bus.out_data, exp);
        n_err++;
      end
    end
    collect("bp");
  endtask

  task automatic test_clear();
    logic [1:0]   tags[4];
    logic [W-1:0] d[4];
    send_beat(2'd0, 3'b111);
    send_beat(2'd1, 3'b111);
    @(negedge clk);
    bus.clear    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_tag   = 2'd2;
    bus.in_data  = 3'b111;
    @(posedge clk);
    #1;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.dup_err !== 1'b0) begin
      $display("FAIL clear_state: out_valid=%b in_ready=%b dup_err=%b, required 0/1/0",
               bus.out_valid, bus.in_ready, bus.dup_err);
      n_err++;
    end
    tags = '{2'd0, 2'd1, 2'd2, 2'd3};
    d    = '{3'b001, 3'b000, 3'b000, 3'b000};
    load_product(tags, d, 7'b0000001, "clear_fresh");
    collect("clear_fresh");
    // Drop an undelivered product while holding.
    d    = '{3'b111, 3'b111, 3'b111, 3'b111};
    for (int i = 0; i < 4; i++) send_beat(tags[i], d[i]);
    @(negedge clk);
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      $display("FAIL clear_hold: out_valid=%b in_ready=%b, required 0/1", bus.out_valid, bus.in_ready);
      n_err++;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]   tags[4];
    logic [W-1:0] d[4];
    tags = '{2'd2, 2'd0, 2'd3, 2'd1};
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) d[i] = W'($urandom_range(0, (1 << W) - 1));
      // d index order follows tags: OE, EE, OO, EO.
      load_product(tags, d, model(d[1], d[3], d[0], d[2]), "b2b");
      collect("b2b");
    end
  endtask

  task automatic test_async_reset();
    logic [1:0]   tags[4];
    logic [W-1:0] d[4];
    send_beat(2'd0, 3'b101);
    send_beat(2'd1, 3'b011);
    send_beat(2'd2, 3'b110);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== '0) begin
      $display("FAIL async_reset: out_valid=%b in_ready=%b out_data=%b, required 0/1/0",
               bus.out_valid, bus.in_ready, bus.out_data);
      n_err++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    tags = '{2'd0, 2'd3, 2'd1, 2'd2};
    d    = '{3'b111, 3'b111, 3'b000, 3'b000};
    load_product(tags, d, 7'b1000001, "after_reset");
    collect("after_reset");
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_tag    = 2'd0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_single_term();
    test_cross_terms();
    test_cancel();
    test_dup();
    test_backpressure();
    test_clear();
    test_back_to_back();
    test_async_reset();
    n_vec++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d products left, required 0", exp_q.size());
      n_err++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
